seq_pattern_det: RTL and testbench

//   Serial pattern detector: shifts in one bit per accepted beat, compares the

---
 rtl/seq_pattern_det_if.sv | 23 ++
 rtl/seq_pattern_det.sv | 89 ++++++++
 tb/tb_seq_pattern_det.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_det_if.sv
// seq_pattern_det_if: serial bit stream in, match/count/window status out
interface seq_pattern_det_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             clr;
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [PAT_W-1:0] window;
    logic             armed;

    modport master (
        output clr, in_valid, in_bit,
        input  match, match_count, window, armed
    );

    modport slave (
        input  clr, in_valid, in_bit,
        output match, match_count, window, armed
    );
endinterface

// File: rtl/seq_pattern_det.sv
// seq_pattern_det: serial pattern detector with fill FSM, match pulse and saturating count
module seq_pattern_det #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_pattern_det_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic {S_FILL, S_ARMED} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic [PAT_W-1:0]   r_window;
    logic [PAT_W-1:0]   w_window_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_match;
    logic               w_match_nxt;
    logic               r_armed;
    logic [PAT_W-1:0]   w_shift;
    logic               w_fill_last;
    logic               w_full;
    logic               w_hit;

    assign w_shift     = {r_window[PAT_W-2:0], bus.in_bit};
    assign w_fill_last = (r_fill == FILL_W'(PAT_W - 1));
    assign w_full      = (r_state == S_ARMED) || w_fill_last;
    assign w_hit       = bus.in_valid && w_full && (w_shift == PATTERN);

    // next-state: clr wins over an accept; a hit in non-overlap mode restarts the fill
    always_comb begin
        w_state_nxt  = r_state;
        w_fill_nxt   = r_fill;
        w_window_nxt = r_window;
        w_count_nxt  = r_count;
        w_match_nxt  = 1'b0;
        if (bus.clr) begin
            w_state_nxt  = S_FILL;
            w_fill_nxt   = '0;
            w_window_nxt = '0;
            w_count_nxt  = '0;
        end else if (bus.in_valid) begin
            w_window_nxt = w_shift;
            if (r_state == S_FILL) begin
                w_fill_nxt  = r_fill + FILL_W'(1);
                w_state_nxt = w_fill_last ? S_ARMED : S_FILL;
            end
            if (w_hit) begin
                w_match_nxt = 1'b1;
                w_count_nxt = (&r_count) ? r_count : r_count + CNT_W'(1);
                if (OVERLAP == 0) begin
                    w_state_nxt = S_FILL;
                    w_fill_nxt  = '0;
                end
            end
        end
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FILL;
            r_fill   <= '0;
            r_window <= '0;
            r_count  <= '0;
            r_match  <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fill   <= w_fill_nxt;
            r_window <= w_window_nxt;
            r_count  <= w_count_nxt;
            r_match  <= w_match_nxt;
            r_armed  <= (w_state_nxt == S_ARMED);
        end
    end

    assign bus.match       = r_match;
    assign bus.match_count = r_count;
    assign bus.window      = r_window;
    assign bus.armed       = r_armed;
endmodule

// File: tb/tb_seq_pattern_det.sv
// tb_seq_pattern_det: three detector configurations fed one stream, scoreboarded against a bit-history model
module tb_seq_pattern_det;
    localparam int PAT_W = 4;
    localparam logic [3:0] PAT = 4'b1010;

    typedef struct packed {
        logic [2:0]      m;
        logic [2:0]      a;
        logic [2:0][3:0] w;
        logic [2:0][7:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   wall[$];
    int   since[3] = '{0, 0, 0};
    int   cnt[3] = '{0, 0, 0};
    int   ovl[3] = '{1, 0, 1};
    int   cmax[3] = '{255, 255, 3};

    always #5 clk = ~clk;

    seq_pattern_det_if #(.PAT_W(4), .CNT_W(8)) if0 ();
    seq_pattern_det_if #(.PAT_W(4), .CNT_W(8)) if1 ();
    seq_pattern_det_if #(.PAT_W(4), .CNT_W(2)) if2 ();

    assign if0.clr = clr;
    assign if0.in_valid = in_valid;
    assign if0.in_bit = in_bit;
    assign if1.clr = clr;
    assign if1.in_valid = in_valid;
    assign if1.in_bit = in_bit;
    assign if2.clr = clr;
    assign if2.in_valid = in_valid;
    assign if2.in_bit = in_bit;

    seq_pattern_det #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    seq_pattern_det #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq_pattern_det #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // reference model: keeps the last bits since reset/clr and, per config, how many bits since the last restart
    always @(posedge clk) begin
        exp_t e;
        int   w;
        logic m;
        e = '0;
        if (!rst_n || clr) begin
            wall.delete();
            for (int k = 0; k < 3; k++) begin
                since[k] = 0;
                cnt[k] = 0;
            end
        end else begin
            if (in_valid) begin
                wall.push_back(int'(in_bit));
                if (wall.size() > PAT_W) void'(wall.pop_front());
            end
            w = 0;
            for (int i = 0; i < wall.size(); i++) w = (w << 1) | wall[i];
            for (int k = 0; k < 3; k++) begin
                m = 1'b0;
                if (in_valid) begin
                    since[k] = since[k] + 1;
                    m = (since[k] >= PAT_W) && (w == int'(PAT));
                    if (m) begin
                        cnt[k] = (cnt[k] < cmax[k]) ? cnt[k] + 1 : cmax[k];
                        if (ovl[k] == 0) since[k] = 0;
                    end
                    if (since[k] > PAT_W) since[k] = PAT_W;
                end
                e.m[k] = m;
                e.a[k] = (since[k] >= PAT_W);
                e.c[k] = 8'(cnt[k]);
                e.w[k] = 4'(w);
            end
        end
        exp_q.push_back(e);
    end

    // monitor: after every edge the DUTs present fresh registered outputs; compare against the oldest expectation
    initial begin
        exp_t e;
        int   am[3], aa[3], ac[3], aw[3];
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                am = '{int'(if0.match), int'(if1.match), int'(if2.match)};
                aa = '{int'(if0.armed), int'(if1.armed), int'(if2.armed)};
                ac = '{int'(if0.match_count), int'(if1.match_count), int'(if2.match_count)};
                aw = '{int'(if0.window), int'(if1.window), int'(if2.window)};
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("match[%0d]", k), am[k], int'(e.m[k]));
                    chk($sformatf("armed[%0d]", k), aa[k], int'(e.a[k]));
                    chk($sformatf("count[%0d]", k), ac[k], int'(e.c[k]));
                    chk($sformatf("window[%0d]", k), aw[k], int'(e.w[k]));
                end
            end
        end
    end

    task automatic beat(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid = v;
        in_bit = b;
        clr = c;
    endtask

    task automatic gap(input int n);
        repeat (n) beat(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap(1);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'(i % 2 == 0), 1'b0);
        gap(2);
        beat(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) beat(1'b1, 1'(i % 2 == 0), 1'b0);
        gap(2);
        beat(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 1'(i % 2 == 0), 1'b0);
            gap(3);
        end
        beat(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) beat(1'b1, 1'(i % 2 == 0), 1'b0);
        gap(2);
        beat(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) beat(1'b1, 1'(i % 2 == 0), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        clr = 1'b0;
        #1;
        chk("async_rst_window", int'(if0.window), 0);
        chk("async_rst_armed", int'(if0.armed), 0);
        chk("async_rst_match", int'(if0.match), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_bit = 1'b0;
        gap(2);
        beat(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'(i % 2 == 1), 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        gap(2);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
        end
        gap(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
